ps2_key_decoder: RTL
====================

Name: ps2_key_decoder

Overview:
- Sits between the PS/2 byte receiver and the game/display logic.
- Consumes the receiver's one-cycle byte strobe and scan-code byte, and parses PS/2 Set-2 make, break (F0) and extended (E0) sequences.
- Produces held-level key flags for both players' paddle keys and a single debounced start/stop pulse, giving the game logic a keyboard alternative to the push-buttons.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- TIMEOUT_US, 2000, max gap between prefix byte and following byte before the sequence is abandoned.
- CODE_AL, 8'h1C, plain code for player A left ("A").
- CODE_AR, 8'h23, plain code for player A right ("D").
- CODE_BL, 8'h6B, extended (E0-prefixed) code for player B left (left arrow).
- CODE_BR, 8'h74, extended code for player B right (right arrow).
- CODE_SS, 8'h29, plain code for start/stop (space).

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  reset, synchronous, active-high.
- ps2_done  in  1  one-cycle strobe, ps2_data valid.
- ps2_data  in  8  received scan-code byte.
- key_AL  out  1  player A left held.
- key_AR  out  1  player A right held.
- key_BL  out  1  player B left held.
- key_BR  out  1  player B right held.
- ss_pulse  out  1  one-cycle pulse on space press (not on repeat).
- last_code  out  9  {ext, code} of most recent make.
- seq_timeout  out  1  one-cycle pulse when a prefix sequence is abandoned.

Behaviour:
- Reset (rst=1 at clk edge):
  - All key flags, internal ss_held, ss_pulse, seq_timeout and last_code go to 0.
  - FSM goes to IDLE; timeout counter goes to 0.
- Timing:
  - Outputs are registered and update on the clk edge after the ps2_done cycle (latency 1).
  - Bytes are only processed when ps2_done=1.
- FSM states: IDLE, EXT, BRK, EXT_BRK.
- IDLE:
  - E0 -> EXT.
  - F0 -> BRK.
  - Ignored with no state change: 00, AA, EE, FA, FE, FF.
  - Any other byte is a plain make: set the matching flag; last_code <= {0, byte}; stay IDLE.
- EXT:
  - F0 -> EXT_BRK.
  - E0 -> stay EXT.
  - Other byte is an extended make: set the matching extended flag; last_code <= {1, byte}; -> IDLE.
- BRK:
  - F0 -> stay BRK.
  - E0 -> EXT_BRK.
  - Other byte: clear the matching plain flag -> IDLE.
- EXT_BRK:
  - F0 or E0 -> stay.
  - Other byte: clear the matching extended flag -> IDLE.
- Code matching:
  - A plain code matches only in non-extended context; an extended code matches only in extended context. So E0 1C does not set key_AL, and a plain 6B does not set key_BL.
  - Unmatched make/break codes still update last_code (makes only) but change no flags.
- Start/stop (ss_pulse):
  - Asserted for exactly one cycle when a plain CODE_SS make arrives and ss_held=0; ss_held is then set.
  - Typematic repeats while held produce no pulse.
  - Break of CODE_SS clears ss_held.
- Timeout:
  - TIMEOUT_CYC = CLK_HZ/1000000*TIMEOUT_US. The counter is 32 bits wide and saturating.
  - In any non-IDLE state, the counter increments each cycle without ps2_done and clears on every ps2_done.
  - At TIMEOUT_CYC-1 the FSM returns to IDLE and seq_timeout pulses for 1 cycle. Flags are unchanged.
  - The counter is held at 0 in IDLE.
- Simultaneous events:
  - ps2_done in the cycle the counter expires: the byte is processed in the current state and no timeout pulse is issued.
- Both directions held:
  - Both flags may be 1 simultaneously; resolution is the consumer's job.
- Mid-sequence reset:
  - A pending prefix is discarded; the next byte after reset is parsed from IDLE.

Test Plan:
- Reset, then bytes 1C, F0, 1C -> key_AL=1 one cycle after the first strobe, key_AL=0 one cycle after the final 1C; last_code=9'h01C.
- E0 6B, then E0 F0 6B -> key_BL 1 then 0; key_AL stays 0; last_code=9'h16B. Plain 6B alone -> no flag change.
- 29, 29, 29 (typematic), F0 29, then 29 -> exactly two ss_pulse cycles: after the first and after the last 29.
- Hold 23 and 1C together, then F0 23 -> key_AR=1 and key_AL=1, then key_AR=0 while key_AL stays 1.
- With CLK_HZ=1000000 and TIMEOUT_US=10: send E0, then wait 10 cycles -> seq_timeout pulses once and FSM is IDLE. Following 6B is a plain code, so key_BL stays 0. Repeat with the strobe landing on the expiry cycle -> no timeout, key_BL=1.
- Send F0, assert rst for 1 cycle, then send 1C -> key_AL=1, since the break was discarded. AA and FA bytes in IDLE -> no output change.

Source files
------------

// File: rtl/ps2_key_decoder.sv
// PS/2 Set-2 scan-code parser: turns receiver byte strobes into held paddle-key flags,
// a start/stop pulse and a timeout pulse for abandoned prefix sequences.
//
// state   | meaning
// IDLE    | no prefix pending; next byte is a plain make or a prefix
// EXT     | E0 seen; next byte is an extended make
// BRK     | F0 seen; next byte is a plain break
// EXT_BRK | E0 and F0 seen; next byte is an extended break
module ps2_key_decoder #(
  parameter int          CLK_HZ     = 50000000,
  parameter int          TIMEOUT_US = 2000,
  parameter logic [7:0]  CODE_AL    = 8'h1C,
  parameter logic [7:0]  CODE_AR    = 8'h23,
  parameter logic [7:0]  CODE_BL    = 8'h6B,
  parameter logic [7:0]  CODE_BR    = 8'h74,
  parameter logic [7:0]  CODE_SS    = 8'h29
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_done,
  input  logic [7:0] ps2_data,
  output logic       key_AL,
  output logic       key_AR,
  output logic       key_BL,
  output logic       key_BR,
  output logic       ss_pulse,
  output logic [8:0] last_code,
  output logic       seq_timeout
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_EXT     = 2'd1;
  localparam logic [1:0] ST_BRK     = 2'd2;
  localparam logic [1:0] ST_EXT_BRK = 2'd3;

  localparam logic [7:0] BYTE_EXT = 8'hE0;
  localparam logic [7:0] BYTE_BRK = 8'hF0;

  localparam logic [31:0] TIMEOUT_CYC = 32'(CLK_HZ / 1000000 * TIMEOUT_US);
  localparam logic [31:0] EXPIRE_CNT  = (TIMEOUT_CYC == 32'd0) ? 32'd0 : TIMEOUT_CYC - 32'd1;

  logic [1:0]  state_q, state_d;
  logic [31:0] to_cnt_q, to_cnt_d;
  logic        key_al_q, key_al_d;
  logic        key_ar_q, key_ar_d;
  logic        key_bl_q, key_bl_d;
  logic        key_br_q, key_br_d;
  logic        ss_held_q, ss_held_d;
  logic        ss_pulse_q, ss_pulse_d;
  logic        seq_timeout_q, seq_timeout_d;
  logic [8:0]  last_code_q, last_code_d;

  logic        byte_ext;
  logic        byte_brk;
  logic        byte_ignored;
  logic        make_en;
  logic        brk_en;
  logic        ext_ctx;

  always_comb begin
    byte_ext     = (ps2_data == BYTE_EXT);
    byte_brk     = (ps2_data == BYTE_BRK);
    byte_ignored = (ps2_data == 8'h00) || (ps2_data == 8'hAA) || (ps2_data == 8'hEE) ||
                   (ps2_data == 8'hFA) || (ps2_data == 8'hFE) || (ps2_data == 8'hFF);
  end

  always_comb begin
    state_d       = state_q;
    to_cnt_d      = to_cnt_q;
    key_al_d      = key_al_q;
    key_ar_d      = key_ar_q;
    key_bl_d      = key_bl_q;
    key_br_d      = key_br_q;
    ss_held_d     = ss_held_q;
    ss_pulse_d    = 1'b0;
    seq_timeout_d = 1'b0;
    last_code_d   = last_code_q;
    make_en       = 1'b0;
    brk_en        = 1'b0;
    ext_ctx       = 1'b0;

    if (ps2_done) begin
      to_cnt_d = 32'd0;
      case (state_q)
        ST_IDLE: begin
          if (byte_ext) begin
            state_d = ST_EXT;
          end else if (byte_brk) begin
            state_d = ST_BRK;
          end else if (!byte_ignored) begin
            make_en = 1'b1;
          end
        end
        ST_EXT: begin
          if (byte_brk) begin
            state_d = ST_EXT_BRK;
          end else if (!byte_ext) begin
            make_en = 1'b1;
            ext_ctx = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_BRK: begin
          if (byte_ext) begin
            state_d = ST_EXT_BRK;
          end else if (!byte_brk) begin
            brk_en  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: begin
          if (!byte_ext && !byte_brk) begin
            brk_en  = 1'b1;
            ext_ctx = 1'b1;
            state_d = ST_IDLE;
          end
        end
      endcase
    end else if (state_q != ST_IDLE) begin
      // A strobe on the expiry cycle wins over the timeout (handled above).
      if (to_cnt_q >= EXPIRE_CNT) begin
        state_d       = ST_IDLE;
        seq_timeout_d = 1'b1;
        to_cnt_d      = 32'd0;
      end else if (to_cnt_q != 32'hFFFF_FFFF) begin
        to_cnt_d = to_cnt_q + 32'd1;
      end
    end else begin
      to_cnt_d = 32'd0;
    end

    if (make_en) begin
      last_code_d = {ext_ctx, ps2_data};
      if (!ext_ctx) begin
        if (ps2_data == CODE_AL) key_al_d = 1'b1;
        if (ps2_data == CODE_AR) key_ar_d = 1'b1;
        if (ps2_data == CODE_SS) begin
          ss_pulse_d = !ss_held_q;
          ss_held_d  = 1'b1;
        end
      end else begin
        if (ps2_data == CODE_BL) key_bl_d = 1'b1;
        if (ps2_data == CODE_BR) key_br_d = 1'b1;
      end
    end

    if (brk_en) begin
      if (!ext_ctx) begin
        if (ps2_data == CODE_AL) key_al_d  = 1'b0;
        if (ps2_data == CODE_AR) key_ar_d  = 1'b0;
        if (ps2_data == CODE_SS) ss_held_d = 1'b0;
      end else begin
        if (ps2_data == CODE_BL) key_bl_d = 1'b0;
        if (ps2_data == CODE_BR) key_br_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      to_cnt_q      <= 32'd0;
      key_al_q      <= 1'b0;
      key_ar_q      <= 1'b0;
      key_bl_q      <= 1'b0;
      key_br_q      <= 1'b0;
      ss_held_q     <= 1'b0;
      ss_pulse_q    <= 1'b0;
      seq_timeout_q <= 1'b0;
      last_code_q   <= 9'd0;
    end else begin
      state_q       <= state_d;
      to_cnt_q      <= to_cnt_d;
      key_al_q      <= key_al_d;
      key_ar_q      <= key_ar_d;
      key_bl_q      <= key_bl_d;
      key_br_q      <= key_br_d;
      ss_held_q     <= ss_held_d;
      ss_pulse_q    <= ss_pulse_d;
      seq_timeout_q <= seq_timeout_d;
      last_code_q   <= last_code_d;
    end
  end

  assign key_AL      = key_al_q;
  assign key_AR      = key_ar_q;
  assign key_BL      = key_bl_q;
  assign key_BR      = key_br_q;
  assign ss_pulse    = ss_pulse_q;
  assign seq_timeout = seq_timeout_q;
  assign last_code   = last_code_q;

endmodule
